// File: rtl/voter_pkg.sv
// rtl/voter_pkg.sv - shared types, mode codes and sizing helper for the sequential voter
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic MODE_MAJ = 1'b0;
  localparam logic MODE_THR = 1'b1;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/seq_voter_if.sv
// rtl/seq_voter_if.sv - vote request / result handshake bundle for seq_voter
interface seq_voter_if #(
  parameter int N_INPUTS = 1001
);
  localparam int CW = $clog2(N_INPUTS + 1);

  logic                in_valid;
  logic                in_ready;
  logic [N_INPUTS-1:0] in_votes;
  logic                mode;
  logic [CW:0]         thresh;
  logic                out_valid;
  logic                out_ready;
  logic                out_vote;
  logic [CW-1:0]       out_count;

  modport master (
    output in_valid, in_votes, mode, thresh, out_ready,
    input  in_ready, out_valid, out_vote, out_count
  );

  modport slave (
    input  in_valid, in_votes, mode, thresh, out_ready,
    output in_ready, out_valid, out_vote, out_count
  );

endinterface

// File: rtl/seq_voter_popcount_chunk.sv
// rtl/seq_voter_popcount_chunk.sv - combinational popcount of one CHUNK-bit slice
module popcount_chunk #(
  parameter  int CHUNK = 64,
  localparam int PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [PW-1:0]    count
);

  // Written as a linear sum; synthesis rebalances it into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/seq_voter.sv
// rtl/seq_voter.sv - majority / threshold voter that popcounts CHUNK bits per cycle
module seq_voter
  import voter_pkg::*;
#(
  parameter int N_INPUTS = 1001,
  parameter int CHUNK    = 64
) (
  input logic       clk,
  input logic       rst,
  seq_voter_if.slave bus
);

  localparam int CW     = $clog2(N_INPUTS + 1);
  localparam int NCHUNK = ceil_div(N_INPUTS, CHUNK);
  localparam int SW     = NCHUNK * CHUNK;
  localparam int IW     = $clog2(NCHUNK + 1);
  localparam int PW     = $clog2(CHUNK + 1);

  if (CHUNK < 1 || CHUNK > N_INPUTS) begin : g_bad_chunk
    $error("seq_voter: CHUNK must be within 1..N_INPUTS");
  end

  state_t        state, state_nx;
  logic [SW-1:0] shreg;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [IW-1:0] idx;
  logic          mode_q;
  logic [CW:0]   thresh_q;
  logic          vote_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] chunk_ones;
  logic          accept;
  logic          last;
  logic          decision;

  popcount_chunk #(.CHUNK(CHUNK)) u_pop (
    .bits  (shreg[CHUNK-1:0]),
    .count (chunk_ones)
  );

  // Gating with rst keeps the block from advertising ready while held in reset.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_vote  = vote_q;
  assign bus.out_count = count_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last     = (idx == IW'(NCHUNK - 1));
  assign count_nx = count + CW'(chunk_ones);
  assign decision = (mode_q == MODE_THR) ? ({1'b0, count_nx} >= thresh_q)
                                         : (count_nx > CW'(N_INPUTS / 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACCUM;
      ACCUM:   if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      count    <= '0;
      idx      <= '0;
      mode_q   <= MODE_MAJ;
      thresh_q <= '0;
      vote_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= SW'(bus.in_votes);
            mode_q   <= bus.mode;
            thresh_q <= bus.thresh;
            count    <= '0;
            idx      <= '0;
          end
        end
        ACCUM: begin
          shreg <= shreg >> CHUNK;
          count <= count_nx;
          idx   <= idx + IW'(1);
          // Result registers load on the final add so DONE presents stable values.
          if (last) begin
            vote_q  <= decision;
            count_q <= count_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
